// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//  md_state_t : state encoding of the iterative mul/div occupancy tracker
//  REG_W      : register id width
//  REG_ZERO   : id of the hard-wired zero register (never a hazard source)
//  regHit     : true when a writer id is non-zero and equals a source id
package hazard_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // Writes to $0 are discarded by the register file, so they never
  // create a dependency even if a source field happens to be 0 too.
  function automatic logic regHit(input logic [REG_W-1:0] writer,
                                  input logic [REG_W-1:0] src);
    return (writer != REG_ZERO) && (writer == src);
  endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Occupancy tracker for the iterative multiply/divide unit.
//  clk    in  core clock, rising edge
//  rst    in  asynchronous reset, active-low
//  start  in  mult/div instruction in Execute launches an operation
//  isDiv  in  qualifies start: 1=div latency, 0=mult latency
//  busy   out unit occupied (BUSY or DONE)
//  done   out one-cycle pulse in the cycle HI/LO is written
// An operation occupies the unit for exactly its latency in cycles,
// counting the final DONE cycle; a new start may launch from DONE.
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic isDiv,
  output logic busy,
  output logic done
);

  localparam int MAX_LAT  = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_BITS = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  typedef logic [CNT_BITS-1:0] cnt_t;

  // The counter is loaded with lat-2: one cycle is spent reaching BUSY
  // and one more in DONE, the remainder is counted down inside BUSY.
  localparam cnt_t MUL_LOAD = cnt_t'((MUL_LAT >= 2) ? (MUL_LAT - 2) : 0);
  localparam cnt_t DIV_LOAD = cnt_t'((DIV_LAT >= 2) ? (DIV_LAT - 2) : 0);

  md_state_t state, nextState;
  cnt_t      cnt, cntNext;
  md_state_t launchState;
  cnt_t      launchCnt;

  // Where a freshly started operation goes: single-cycle ops skip BUSY.
  always_comb begin
    launchState = BUSY;
    launchCnt   = isDiv ? DIV_LOAD : MUL_LOAD;
    if ((isDiv && (DIV_LAT == 1)) || (!isDiv && (MUL_LAT == 1))) begin
      launchState = DONE;
    end
  end

  // Next-state and output logic.
  always_comb begin
    nextState = state;
    cntNext   = cnt;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          nextState = launchState;
          cntNext   = launchCnt;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cntNext = cnt - cnt_t'(1);
        end else begin
          nextState = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
        if (start) begin
          nextState = launchState;
          cntNext   = launchCnt;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // State register; reset aborts any operation without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
    end
  end

  assign busy = (state != IDLE);

  // The hazard logic stalls Decode while the unit is occupied, so a new
  // start can never reach Execute during BUSY; flag it if it does.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!((state == BUSY) && start));
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller for the 5-stage MIPS core.
//  clk, rst                 clock / asynchronous active-low reset
//  rsD, rtD                 Decode source registers
//  rsE                      Execute rs (observation only, no hazard use)
//  writeRegisterE/M         destination registers in Execute / Memory
//  regWriteE, memToRegE/M   Execute writes regfile / is a load; Memory is a load
//  branchD, jrD             Decode compares operands / reads rs in Decode
//  branchTakenD             Decode resolved a redirect
//  mdStartE, mdDivE         mul/div launching in Execute, div qualifier
//  mdStartD, mfhiloD        Decode instruction needs the HI/LO unit
//  stallF, stallD, flushE   hold fetch/decode and bubble Execute
//  flushD                   squash the fetched instruction on redirect
//  mdBusy, mdDone           mul/div unit occupied / HI/LO written
//  stallCount               saturating count of Decode stall cycles
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic [REG_W-1:0] rsE,
  input  logic [REG_W-1:0] writeRegisterE,
  input  logic [REG_W-1:0] writeRegisterM,
  input  logic             regWriteE,
  input  logic             memToRegE,
  input  logic             memToRegM,
  input  logic             branchD,
  input  logic             jrD,
  input  logic             branchTakenD,
  input  logic             mdStartE,
  input  logic             mdDivE,
  input  logic             mdStartD,
  input  logic             mfhiloD,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE,
  output logic             mdBusy,
  output logic             mdDone,
  output logic [CNT_W-1:0] stallCount
);

  logic lwStall, brStall, mdStall, stall;
  logic hitE, hitM;
  logic unusedRsE;

  assign unusedRsE = ^rsE;

  md_busy_tracker #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) mdTracker (
    .clk  (clk),
    .rst  (rst),
    .start(mdStartE),
    .isDiv(mdDivE),
    .busy (mdBusy),
    .done (mdDone)
  );

  // A jr only reads rs in Decode; a branch compares both rs and rt.
  // Outputs are held inactive while reset is asserted.
  always_comb begin
    hitE    = regHit(writeRegisterE, rsD) | (branchD & regHit(writeRegisterE, rtD));
    hitM    = regHit(writeRegisterM, rsD) | (branchD & regHit(writeRegisterM, rtD));
    lwStall = memToRegE & regWriteE &
              (regHit(writeRegisterE, rsD) | regHit(writeRegisterE, rtD));
    brStall = (branchD | jrD) & ((regWriteE & hitE) | (memToRegM & hitM));
    mdStall = (mfhiloD | mdStartD) & (mdStartE | mdBusy);
    stall   = rst & (lwStall | brStall | mdStall);
  end

  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall;
  // A stalled branch compares stale operands, so it may only redirect
  // once it is allowed to leave Decode.
  assign flushD = rst & branchTakenD & ~stall;

  // Performance counter; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCount <= '0;
    end else if (stall && (stallCount != '1)) begin
      stallCount <= stallCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit (CNT_W=4 build).
module tb_hazard_control_unit;

  localparam logic [9:0] REGWE = 10'h200;
  localparam logic [9:0] LOADE = 10'h100;
  localparam logic [9:0] LOADM = 10'h080;
  localparam logic [9:0] BRD   = 10'h040;
  localparam logic [9:0] JRD   = 10'h020;
  localparam logic [9:0] TAKEN = 10'h010;
  localparam logic [9:0] MDSE  = 10'h008;
  localparam logic [9:0] MDDIV = 10'h004;
  localparam logic [9:0] MDSD  = 10'h002;
  localparam logic [9:0] HILOD = 10'h001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rsD = '0, rtD = '0, rsE = '0, writeRegisterE = '0, writeRegisterM = '0;
  logic       regWriteE = 0, memToRegE = 0, memToRegM = 0, branchD = 0, jrD = 0;
  logic       branchTakenD = 0, mdStartE = 0, mdDivE = 0, mdStartD = 0, mfhiloD = 0;
  logic       stallF, stallD, flushD, flushE, mdBusy, mdDone;
  logic [3:0] stallCount;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(
    .MUL_LAT(4),
    .DIV_LAT(32),
    .CNT_W  (4)
  ) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE),
    .writeRegisterE(writeRegisterE), .writeRegisterM(writeRegisterM),
    .regWriteE(regWriteE), .memToRegE(memToRegE), .memToRegM(memToRegM),
    .branchD(branchD), .jrD(jrD), .branchTakenD(branchTakenD),
    .mdStartE(mdStartE), .mdDivE(mdDivE), .mdStartD(mdStartD), .mfhiloD(mfhiloD),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .mdBusy(mdBusy), .mdDone(mdDone), .stallCount(stallCount)
  );

  // Drive one cycle's worth of inputs right after the rising edge and
  // return 3 time units later, well clear of both clock edges.
  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] wrE, input logic [4:0] wrM,
                               input logic [9:0] flags);
    @(posedge clk);
    #1;
    rsD = rs;
    rtD = rt;
    rsE = rs;
    writeRegisterE = wrE;
    writeRegisterM = wrM;
    {regWriteE, memToRegE, memToRegM, branchD, jrD, branchTakenD,
     mdStartE, mdDivE, mdStartD, mfhiloD} = flags;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic checkCount(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkStall(input string tag, input logic expected);
    checkOutput({tag, ".stallF"}, stallF, expected);
    checkOutput({tag, ".stallD"}, stallD, expected);
    checkOutput({tag, ".flushE"}, flushE, expected);
  endtask

  initial begin
    #1 rst = 1'b0;

    // Reset holds every output low even with a load-use hazard present.
    applyStimulus(5'd2, 5'd0, 5'd2, 5'd0, REGWE | LOADE);
    checkStall("rst", 1'b0);
    checkOutput("rst.mdBusy", mdBusy, 1'b0);
    checkOutput("rst.mdDone", mdDone, 1'b0);
    checkCount("rst.count", stallCount, 4'd0);
    applyStimulus(5'd0, 5'd0, 5'd0, 5'd0, 10'h000);
    rst = 1'b1;

    // Load-use through rt, bubble moves the load on, then $0 never hazards.
    applyStimulus(5'd1, 5'd2, 5'd2, 5'd0, REGWE | LOADE);
    checkStall("lw.rt", 1'b1);
    checkCount("lw.count0", stallCount, 4'd0);
    applyStimulus(5'd1, 5'd2, 5'd2, 5'd2, LOADM);
    checkStall("lw.released", 1'b0);
    checkCount("lw.count1", stallCount, 4'd1);
    applyStimulus(5'd0, 5'd0, 5'd0, 5'd0, REGWE | LOADE);
    checkStall("lw.zero", 1'b0);

    // beq waits on ALU result in E, then on a load in M, then redirects once.
    applyStimulus(5'd5, 5'd7, 5'd5, 5'd0, BRD | REGWE);
    checkStall("br.E", 1'b1);
    checkOutput("br.E.flushD", flushD, 1'b0);
    applyStimulus(5'd5, 5'd7, 5'd5, 5'd5, BRD | LOADM | TAKEN);
    checkStall("br.M", 1'b1);
    checkOutput("br.M.flushD", flushD, 1'b0);
    applyStimulus(5'd5, 5'd7, 5'd0, 5'd5, BRD | TAKEN);
    checkStall("br.go", 1'b0);
    checkOutput("br.go.flushD", flushD, 1'b1);
    checkCount("br.count", stallCount, 4'd3);

    // jr ignores rt; reading rs from E stalls; branch against $0 does not.
    applyStimulus(5'd4, 5'd9, 5'd9, 5'd0, JRD | REGWE);
    checkStall("jr.rt", 1'b0);
    checkOutput("jr.rt.flushD", flushD, 1'b0);
    applyStimulus(5'd9, 5'd4, 5'd9, 5'd0, JRD | REGWE);
    checkStall("jr.rs", 1'b1);
    applyStimulus(5'd0, 5'd0, 5'd0, 5'd0, BRD | REGWE);
    checkStall("br.zero", 1'b0);
    checkCount("jr.count", stallCount, 4'd4);

    // mult in E with mflo in D: stall start cycle plus 4 busy cycles.
    applyStimulus(5'd0, 5'd0, 5'd0, 5'd0, MDSE | HILOD);
    checkStall("mul.start", 1'b1);
    checkOutput("mul.start.busy", mdBusy, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(5'd0, 5'd0, 5'd0, 5'd0, HILOD);
      checkStall("mul.occ", 1'b1);
      checkOutput("mul.occ.busy", mdBusy, 1'b1);
      checkOutput("mul.occ.done", mdDone, (i == 4));
    end
    applyStimulus(5'd0, 5'd0, 5'd0, 5'd0, HILOD);
    checkStall("mul.free", 1'b0);
    checkOutput("mul.free.busy", mdBusy, 1'b0);
    checkOutput("mul.free.done", mdDone, 1'b0);
    checkCount("mul.count", stallCount, 4'd9);

    // div aborted by reset partway: unit idles, counter clears, no done.
    applyStimulus(5'd0, 5'd0, 5'd0, 5'd0, MDSE | MDDIV);
    checkStall("div.start", 1'b0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(5'd0, 5'd0, 5'd0, 5'd0, 10'h000);
      checkOutput("div.busy", mdBusy, 1'b1);
      checkOutput("div.done", mdDone, 1'b0);
    end
    checkCount("div.count", stallCount, 4'd9);
    rst = 1'b0;
    #2;
    checkOutput("div.rst.busy", mdBusy, 1'b0);
    checkOutput("div.rst.done", mdDone, 1'b0);
    checkCount("div.rst.count", stallCount, 4'd0);
    #2 rst = 1'b1;
    for (int i = 0; i < 35; i++) begin
      applyStimulus(5'd0, 5'd0, 5'd0, 5'd0, 10'h000);
      checkOutput("div.after.busy", mdBusy, 1'b0);
      checkOutput("div.after.done", mdDone, 1'b0);
    end

    // Continuous load-use stall drives the 4-bit counter into saturation.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(5'd3, 5'd0, 5'd3, 5'd0, REGWE | LOADE);
      checkStall("sat.stall", 1'b1);
      checkCount("sat.count", stallCount, (k < 15) ? 4'(k) : 4'd15);
    end
    applyStimulus(5'd0, 5'd0, 5'd0, 5'd0, 10'h000);
    checkStall("sat.end", 1'b0);
    checkCount("sat.hold", stallCount, 4'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net in case the stimulus ever stops advancing.
  initial begin
    #20000;
    $display("[TB] FAIL timeout: simulation did not complete, vectors %0d", vectors);
    $fatal(1, "[TB] timeout");
  end

endmodule
